// File: rtl/sorted_vector_streamer_if.sv
// rtl/sorted_vector_streamer_if.sv - vector-in / element-out handshake bundle for the streamer
interface sorted_vector_streamer_if #(
  parameter int WIDTH = 3,
  parameter int N     = 8,
  parameter int IDXW  = $clog2(N)
) ();
  logic                 in_valid;
  logic                 in_ready;
  logic [N*WIDTH-1:0]   in_data;
  logic                 out_valid;
  logic                 out_ready;
  logic [WIDTH-1:0]     out_data;
  logic [IDXW-1:0]      out_idx;
  logic                 out_last;
  logic                 order_err;

  // Producer of vectors and consumer of elements (the surrounding logic).
  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_idx, out_last, order_err
  );

  // The streamer itself.
  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_idx, out_last, order_err
  );
endinterface

// File: rtl/sorted_vector_streamer.sv
// rtl/sorted_vector_streamer.sv - streams a sorted N-element vector one element per beat with order check
module sorted_vector_streamer #(
  parameter int WIDTH = 3,
  parameter int N     = 8,
  parameter int IDXW  = $clog2(N)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  sorted_vector_streamer_if.slave bus
);

  typedef enum logic {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } state_t;

  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(N - 1);

  state_t               state_q, state_d;
  logic [N*WIDTH-1:0]   vec_q, vec_d;
  logic [IDXW-1:0]      idx_q, idx_d;
  logic                 err_q, err_d;

  logic                 streaming;
  logic                 at_last;
  logic                 beat_done;
  logic                 in_ready_w;
  logic                 capture;
  logic                 in_err;

  assign streaming = (state_q == STREAM);
  assign at_last   = streaming && (idx_q == LAST_IDX);
  assign beat_done = streaming && bus.out_ready;
  assign capture   = bus.in_valid && in_ready_w;

  // Flag the incoming vector if any neighbouring pair steps downward.
  always_comb begin
    in_err = 1'b0;
    for (int k = 0; k < N - 1; k++) begin
      if (bus.in_data[(k+1)*WIDTH +: WIDTH] < bus.in_data[k*WIDTH +: WIDTH]) begin
        in_err = 1'b1;
      end
    end
  end

  // State register; reset drops any vector still being streamed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state: a last beat either chains straight into a new vector or returns to idle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (capture) state_d = STREAM;
      end
      STREAM: begin
        if (beat_done && at_last && !capture) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs: element select by rank, and acceptance of a new vector on the final beat.
  always_comb begin
    in_ready_w    = (state_q == IDLE) || (beat_done && at_last);
    bus.in_ready  = in_ready_w;
    bus.out_valid = streaming;
    bus.out_data  = streaming ? vec_q[int'(idx_q)*WIDTH +: WIDTH] : '0;
    bus.out_idx   = idx_q;
    bus.out_last  = at_last;
    bus.order_err = streaming && err_q;
  end

  // Datapath next values: capture restarts the rank, a non-final beat advances it.
  always_comb begin
    vec_d = vec_q;
    idx_d = idx_q;
    err_d = err_q;
    if (capture) begin
      vec_d = bus.in_data;
      idx_d = '0;
      err_d = in_err;
    end else if (beat_done && !at_last) begin
      idx_d = idx_q + 1'b1;
    end
  end

  // Datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vec_q <= '0;
      idx_q <= '0;
      err_q <= 1'b0;
    end else begin
      vec_q <= vec_d;
      idx_q <= idx_d;
      err_q <= err_d;
    end
  end

endmodule

// File: tb/tb_sorted_vector_streamer.sv
// tb/tb_sorted_vector_streamer.sv - scoreboard bench for sorted_vector_streamer
module tb_sorted_vector_streamer;

  localparam int W  = 3;
  localparam int N  = 8;
  localparam int IW = $clog2(N);

  typedef struct {
    int data;
    int idx;
    int last;
    int err;
  } beat_t;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;
  int   cyc;
  int   beat_cnt;
  int   rdy_mode;
  int   beat_time [int];
  beat_t exp_q [$];

  sorted_vector_streamer_if #(.WIDTH(W), .N(N), .IDXW(IW)) svs_if ();

  sorted_vector_streamer #(.WIDTH(W), .N(N), .IDXW(IW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (svs_if.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: the elements in rank order, and err set exactly when the vector is not already sorted.
  function automatic void push_exp(input logic [N*W-1:0] v);
    int e[$];
    int s[$];
    int bad;
    beat_t b;
    for (int k = 0; k < N; k++) e.push_back(int'(v[k*W +: W]));
    s = e;
    s.sort();
    bad = 0;
    for (int k = 0; k < N; k++) if (s[k] != e[k]) bad = 1;
    for (int k = 0; k < N; k++) begin
      b.data = e[k];
      b.idx  = k;
      b.last = (k == N - 1) ? 1 : 0;
      b.err  = bad;
      exp_q.push_back(b);
    end
  endfunction

  function automatic logic [N*W-1:0] pack(input int e[N]);
    logic [N*W-1:0] v;
    v = '0;
    for (int k = 0; k < N; k++) v[k*W +: W] = W'(e[k]);
    return v;
  endfunction

  // Called at a falling edge; returns at the falling edge after acceptance with in_valid still high.
  task automatic send(input logic [N*W-1:0] v);
    int t;
    t = 0;
    svs_if.in_valid = 1'b1;
    svs_if.in_data  = v;
    forever begin
      #1;
      if (svs_if.in_ready) begin
        push_exp(v);
        @(negedge clk);
        break;
      end
      @(negedge clk);
      t++;
      if (t > 1000) begin
        chk("send_timeout", 0, 1);
        break;
      end
    end
  endtask

  task automatic idle();
    svs_if.in_valid = 1'b0;
    svs_if.in_data  = (N*W)'($urandom);
    @(negedge clk);
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 2000) begin
      @(negedge clk);
      t++;
    end
    chk("drain_left", exp_q.size(), 0);
    @(negedge clk);
  endtask

  function automatic int span(input int first, input int last);
    if (!beat_time.exists(first) || !beat_time.exists(last)) return -1;
    return beat_time[last] - beat_time[first];
  endfunction

  // Monitor: drives out_ready, then pops and compares every completed beat and checks stall stability.
  initial begin
    int held;
    int hd;
    int hi;
    beat_t b;
    held = 0;
    hd = 0;
    hi = 0;
    svs_if.out_ready = 1'b1;
    forever begin
      @(negedge clk);
      case (rdy_mode)
        0:       svs_if.out_ready = 1'b1;
        1:       svs_if.out_ready = 1'($urandom_range(0, 1));
        default: svs_if.out_ready = ((cyc % 4) == 0 || (cyc % 4) == 3);
      endcase
      #1;
      if (!rst_n) begin
        held = 0;
        continue;
      end
      if (held != 0) begin
        chk("stall_valid", int'(svs_if.out_valid), 1);
        chk("stall_data", int'(svs_if.out_data), hd);
        chk("stall_idx", int'(svs_if.out_idx), hi);
      end
      chk("in_ready", int'(svs_if.in_ready),
          (!svs_if.out_valid || (svs_if.out_ready && svs_if.out_last)) ? 1 : 0);
      if (svs_if.out_valid && svs_if.out_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_beat", 1, 0);
        end else begin
          b = exp_q.pop_front();
          chk("out_data", int'(svs_if.out_data), b.data);
          chk("out_idx", int'(svs_if.out_idx), b.idx);
          chk("out_last", int'(svs_if.out_last), b.last);
          chk("order_err", int'(svs_if.order_err), b.err);
        end
        beat_time[beat_cnt] = cyc;
        beat_cnt++;
        held = 0;
      end else if (svs_if.out_valid) begin
        held = 1;
        hd = int'(svs_if.out_data);
        hi = int'(svs_if.out_idx);
      end else begin
        held = 0;
      end
    end
  end

  initial begin
    int b0;
    int t;
    int e[N];
    logic [N*W-1:0] v;
    checks = 0;
    errors = 0;
    cyc = 0;
    beat_cnt = 0;
    rdy_mode = 0;
    svs_if.in_valid = 1'b0;
    svs_if.in_data  = '0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_out_valid", int'(svs_if.out_valid), 0);
    chk("rst_out_data", int'(svs_if.out_data), 0);
    chk("rst_out_idx", int'(svs_if.out_idx), 0);
    chk("rst_out_last", int'(svs_if.out_last), 0);
    chk("rst_order_err", int'(svs_if.order_err), 0);
    chk("rst_in_ready", int'(svs_if.in_ready), 1);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Single ascending vector at full rate.
    b0 = beat_cnt;
    send(pack('{0, 1, 2, 3, 4, 5, 6, 7}));
    idle();
    drain();
    chk("single_span", span(b0, b0 + 7), 7);

    // Back-to-back vectors with no bubble.
    b0 = beat_cnt;
    send(pack('{1, 1, 2, 3, 3, 5, 6, 7}));
    send(pack('{0, 0, 0, 0, 7, 7, 7, 7}));
    idle();
    drain();
    chk("b2b_span", span(b0, b0 + 15), 15);

    // Backpressure pattern 1,0,0,1.
    rdy_mode = 2;
    send(pack('{2, 2, 3, 4, 4, 5, 6, 7}));
    idle();
    drain();
    rdy_mode = 0;

    // Out-of-order vector followed by a sorted one.
    send(pack('{0, 1, 2, 5, 4, 5, 6, 7}));
    send(pack('{0, 1, 2, 3, 4, 5, 6, 7}));
    idle();
    drain();

    // Asynchronous reset after the third beat.
    b0 = beat_cnt;
    send(pack('{0, 1, 2, 3, 4, 5, 6, 7}));
    idle();
    t = 0;
    while (beat_cnt < b0 + 3 && t < 100) begin
      @(negedge clk);
      #2;
      t++;
    end
    chk("mid_reset_reached", (beat_cnt >= b0 + 3) ? 1 : 0, 1);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_out_valid", int'(svs_if.out_valid), 0);
    chk("mid_rst_out_data", int'(svs_if.out_data), 0);
    chk("mid_rst_out_idx", int'(svs_if.out_idx), 0);
    chk("mid_rst_in_ready", int'(svs_if.in_ready), 1);
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Equal elements after the reset.
    send(pack('{3, 3, 3, 3, 3, 3, 3, 3}));
    idle();
    drain();

    // Randomized traffic with random backpressure, idle gaps, and occasional unsorted vectors.
    rdy_mode = 1;
    for (int n = 0; n < 60; n++) begin
      for (int k = 0; k < N; k++) e[k] = int'($urandom_range(0, (1 << W) - 1));
      if ($urandom_range(0, 3) != 0) e.sort();
      v = pack(e);
      send(v);
      if ($urandom_range(0, 1) != 0) begin
        repeat ($urandom_range(1, 3)) idle();
      end
    end
    idle();
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
